// File: rtl/mem_responder_pkg.sv
// Shared types and widths for the mem_responder block and its word array.
package mem_responder_pkg;

  localparam int WORD_W = 16;
  localparam int MASK_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

endpackage

// File: rtl/mem_responder_array.sv
// Word array for mem_responder: one synchronous byte-masked write port, one combinational read port.
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [MASK_W-1:0]    wmask,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WORD_W-1:0]    wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WORD_W-1:0]    rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_BITS];

  // Contents are intentionally not reset; only enabled bytes are touched.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (wmask[b]) begin
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder with fixed wait states and byte-masked writes.
// Optional MEM_RESPONDER_STATS_EN adds completed read/write counters.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int LATENCY   = 2,
  parameter int ADDR_BITS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [MASK_W-1:0] wmask,
  input  logic [15:0]       address,
  input  logic [WORD_W-1:0] wdata,
  output logic              resp,
  output logic [WORD_W-1:0] rdata
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t               state, state_nxt;
  logic [3:0]           cnt, cnt_nxt;
  op_t                  op_q;
  logic                 rd_q;
  logic                 accept;
  logic                 load_rdata;
  logic                 req;
  logic [ADDR_BITS-1:0] idx_q;
  logic [ADDR_BITS-1:0] raddr;
  logic [MASK_W-1:0]    mask_q;
  logic [WORD_W-1:0]    wdata_q;
  logic [WORD_W-1:0]    arr_rdata;
  logic                 arr_we;
  logic                 unused_addr;

  assign req         = read | write;
  assign unused_addr = ^address;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= OP_RD;
      rd_q  <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        op_q <= write ? OP_WR : OP_RD;
        rd_q <= read;
      end
      if (load_rdata) begin
        rdata <= arr_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= address[ADDR_BITS:1];
      mask_q  <= wmask;
      wdata_q <= wdata;
    end
  end

  // The edge that moves WAIT->RESP is the one where the count reaches its last step,
  // so the request accepted at the end of cycle t completes in cycle t+LATENCY.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_nxt = RESP;
            cnt_nxt   = '0;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt <= 4'd1) begin
          state_nxt = RESP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // With single-cycle latency the index is not latched yet when rdata loads.
  assign raddr      = accept ? address[ADDR_BITS:1] : idx_q;
  assign load_rdata = (state_nxt == RESP) && (accept ? read : rd_q);
  assign resp       = (state == RESP);
  assign arr_we     = (state == RESP) && (op_q == OP_WR);

  mem_responder_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .wmask(mask_q),
    .waddr(idx_q),
    .wdata(wdata_q),
    .raddr(raddr),
    .rdata(arr_rdata)
  );

`ifdef MEM_RESPONDER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == RESP) begin
      if (op_q == OP_WR) begin
        wr_count <= wr_count + 16'd1;
      end else begin
        rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY=2).
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  wmask = 2'b00;
  logic [15:0] address = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic        resp;
  logic [15:0] rdata;
`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  int checks = 0;
  int errors = 0;

  mem_responder #(
    .LATENCY  (LAT),
    .ADDR_BITS(10)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .read   (read),
    .write  (write),
    .wmask  (wmask),
    .address(address),
    .wdata  (wdata),
    .resp   (resp),
    .rdata  (rdata)
`ifdef MEM_RESPONDER_STATS_EN
    ,
    .rd_count(rd_count),
    .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request in the current cycle, hold it until resp, then drop it.
  task automatic txn(input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [15:0] wd, input logic [1:0] m, input string tag);
    int n;
    n = 0;
    read = rd; write = wr; address = addr; wdata = wd; wmask = m;
    do begin
      tick();
      n++;
    end while (!resp && n < 20);
    check({tag, "_lat"}, 32'(n), 32'(LAT));
    read = 1'b0; write = 1'b0;
    tick();
    check({tag, "_pulse"}, 32'(resp), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] held;
    logic        exp_resp;

    // Reset state
    tick();
    tick();
    check("rst_resp", 32'(resp), 32'd0);
    check("rst_rdata", 32'(rdata), 32'h0000);
    rst_n = 1'b1;

    // Test 1: preload then cycle-accurate read
    txn(1'b0, 1'b1, 16'h0020, 16'hBEEF, 2'b11, "preload");
    read = 1'b1; address = 16'h0020;
    check("t1_c0_resp", 32'(resp), 32'd0);
    tick();
    check("t1_c1_resp", 32'(resp), 32'd0);
    tick();
    check("t1_c2_resp", 32'(resp), 32'd1);
    check("t1_c2_rdata", 32'(rdata), 32'hBEEF);
    read = 1'b0;
    tick();
    check("t1_c3_resp", 32'(resp), 32'd0);
    check("t1_c3_rdata", 32'(rdata), 32'hBEEF);

    // Aliasing: address bit 0 and bits above the index are ignored
    txn(1'b1, 1'b0, 16'h0821, 16'h0000, 2'b00, "alias");
    check("alias_rdata", 32'(rdata), 32'hBEEF);

    // Test 2: byte-masked writes
    txn(1'b0, 1'b1, 16'h0020, 16'h1234, 2'b01, "wr_lo");
    check("wr_no_rdata", 32'(rdata), 32'hBEEF);
    txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, "rd_lo");
    check("t2_rdata", 32'(rdata), 32'hBE34);
    txn(1'b0, 1'b1, 16'h0020, 16'hFFFF, 2'b00, "wr_none");
    txn(1'b0, 1'b1, 16'h0020, 16'hAA00, 2'b10, "wr_hi");
    txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, "rd_hi");
    check("mask_rdata", 32'(rdata), 32'hAA34);

    // Simultaneous read and write: written, rdata shows the old word
    txn(1'b1, 1'b1, 16'h0020, 16'h5555, 2'b11, "rdwr");
    check("rdwr_rdata", 32'(rdata), 32'hAA34);
    txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, "rd_after");
    check("rdwr_after", 32'(rdata), 32'h5555);

    // Test 3: held read, pulses in cycles 2, 5, 8
    read = 1'b1; address = 16'h0020;
    for (int c = 0; c < 9; c++) begin
      exp_resp = (c == 2) || (c == 5) || (c == 8);
      check($sformatf("t3_c%0d", c), 32'(resp), 32'(exp_resp));
      if (c < 8) tick();
    end
    read = 1'b0;
    tick();
    check("t3_end", 32'(resp), 32'd0);

    // Test 4: aborted read and aborted write
    held = rdata;
    read = 1'b1; address = 16'h0040;
    tick();
    read = 1'b0;
    for (int c = 1; c < 5; c++) begin
      check($sformatf("t4_rd_c%0d", c), 32'(resp), 32'd0);
      tick();
    end
    check("t4_rdata", 32'(rdata), 32'(held));
    write = 1'b1; address = 16'h0020; wdata = 16'h0000; wmask = 2'b11;
    tick();
    write = 1'b0;
    for (int c = 1; c < 4; c++) begin
      check($sformatf("t4_wr_c%0d", c), 32'(resp), 32'd0);
      tick();
    end
    txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, "t4_chk");
    check("t4_word", 32'(rdata), 32'h5555);

    // Test 5: reset mid-write
    write = 1'b1; address = 16'h0020; wdata = 16'h0F0F; wmask = 2'b11;
    tick();
    rst_n = 1'b0;
    #1;
    check("t5_resp", 32'(resp), 32'd0);
    check("t5_rdata", 32'(rdata), 32'h0000);
    write = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, "t5_rd");
    check("t5_word", 32'(rdata), 32'h5555);

    // Reset during the resp cycle drops resp at once
    read = 1'b1; address = 16'h0020;
    tick();
    tick();
    check("t5b_resp_hi", 32'(resp), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5b_resp_lo", 32'(resp), 32'd0);
    read = 1'b0;
    tick();
    rst_n = 1'b1;

`ifdef MEM_RESPONDER_STATS_EN
    // Test 6: statistics counters
    do_reset();
    check("t6_rd0", 32'(rd_count), 32'd0);
    check("t6_wr0", 32'(wr_count), 32'd0);
    txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, "s_rd1");
    txn(1'b0, 1'b1, 16'h0022, 16'h1111, 2'b11, "s_wr1");
    txn(1'b1, 1'b0, 16'h0022, 16'h0000, 2'b00, "s_rd2");
    read = 1'b1; address = 16'h0024;
    tick();
    read = 1'b0;
    tick();
    tick();
    txn(1'b0, 1'b1, 16'h0024, 16'h2222, 2'b01, "s_wr2");
    txn(1'b1, 1'b0, 16'h0024, 16'h0000, 2'b00, "s_rd3");
    check("t6_rd", 32'(rd_count), 32'd3);
    check("t6_wr", 32'(wr_count), 32'd2);
`else
    do_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable memory responder for the 16-bit read/write/resp handshake that the datapath uses as initiator.
- Replaces the zero-cost behavioural memory with a block that has fixed, programmable wait states and byte-masked writes.
- Sits between an initiator (datapath instruction or data port) and an internal word array.
- Used in benches and as the on-chip memory stub for timing-realistic runs.

Parameters:
- LATENCY, 2, cycles from the request being accepted to resp; legal range 1..15.
- ADDR_BITS, 10, word-index width; array holds 2**ADDR_BITS 16-bit words.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- read  in  1  read request, held by initiator until resp
- write  in  1  write request, held by initiator until resp
- wmask  in  2  byte enables for write; bit0 = [7:0], bit1 = [15:8]
- address  in  16  byte address; bit0 ignored; word index = address[ADDR_BITS:1]; higher bits ignored (aliasing)
- wdata  in  16  write data
- resp  out  1  one-cycle completion pulse
- rdata  out  16  read data, registered

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, resp=0, rdata=16'h0000, latency counter=0, pending write discarded.
  - Array contents are not reset.
- States:
  - IDLE: if read|write is sampled high at an edge, latch op, address, wmask and wdata; load counter with LATENCY-1; go to WAIT. A request first high in cycle t gets resp=1 in cycle t+LATENCY.
  - WAIT: counter decrements each edge. When counter==0 at an edge (request still held), go to RESP.
  - RESP: resp=1 for exactly this cycle.
    - Read: rdata = array[latched index] throughout the cycle.
    - Write: committed at the edge ending this cycle.
    - Next state is IDLE. The request is sampled again at the following edge, so a held request restarts immediately; back-to-back throughput is one transaction per LATENCY+1 cycles.
- Write masking: only bytes with wmask bit=1 are updated. wmask=2'b00 completes with resp but changes nothing.
- Simultaneous read & write: treated as write. rdata returns the pre-write word.
- Abort: if read and write are both low at any WAIT edge, return to IDLE with no resp and no write. Address/data changes mid-WAIT are ignored (latched values used).
- rdata holds its last read value outside RESP. Writes do not update rdata.
- Reset mid-transaction: resp drops immediately; the write is not performed.

Optional Feature:
- MEM_RESPONDER_STATS_EN defined: adds ports
  - rd_count  out  16: completed reads
  - wr_count  out  16: completed writes
  - Both reset to 0, increment on each resp for the corresponding op, wrap 16'hFFFF→0. Aborted requests are not counted.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- mem_responder_pkg holds:
  - state enum (IDLE, WAIT, RESP)
  - WORD_W=16, MASK_W=2
  - op enum (OP_RD, OP_WR)
- One sub-module, mem_responder_array: word array with one synchronous byte-masked write port and one combinational read port. FSM, counter and registers stay in mem_responder.

Test Plan:
1. LATENCY=2. Preload word 0x0010 with 16'hBEEF. read=1, address=16'h0020 at cycle 0 → resp=1 only in cycle 2, rdata=16'hBEEF in cycle 2 and held afterward.
2. Write address 16'h0020, wdata=16'h1234, wmask=2'b01 over 16'hBEEF → resp in cycle 2; a subsequent read returns 16'hBE34.
3. read held continuously for 9 cycles with LATENCY=2 → resp pulses in cycles 2, 5, 8; never high two cycles in a row.
4. read asserted in cycle 0 and dropped in cycle 1 → no resp; rdata unchanged. Write asserted in cycle 0 and dropped in cycle 1 → array word unchanged.
5. Write issued, rst_n pulsed low in cycle 1 → resp=0 and rdata=0 immediately; the target word keeps its old value; the next read completes normally.
6. With MEM_RESPONDER_STATS_EN: 3 reads, 2 writes, 1 aborted read → rd_count=3, wr_count=2.
